// File: rtl/window_gen_3x3.sv
// window_gen_3x3
// Streaming 3x3 neighbourhood generator. Two line buffers hold the previous
// two lines; a 3x3 register window shifts left on every accepted pixel and
// a row-fill FSM keeps win_valid low until the window holds real image data.
module window_gen_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 640
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  sof,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  output logic [DATA_WIDTH-1:0] win00,
  output logic [DATA_WIDTH-1:0] win01,
  output logic [DATA_WIDTH-1:0] win02,
  output logic [DATA_WIDTH-1:0] win10,
  output logic [DATA_WIDTH-1:0] win11,
  output logic [DATA_WIDTH-1:0] win12,
  output logic [DATA_WIDTH-1:0] win20,
  output logic [DATA_WIDTH-1:0] win21,
  output logic [DATA_WIDTH-1:0] win22,
  output logic                  win_valid
);

  localparam int CW = $clog2(LINE_WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);

  typedef enum logic [1:0] {
    S_ROW0 = 2'd0,
    S_ROW1 = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_eff;
  state_t                w_state_next;
  logic [CW-1:0]         r_col;
  logic [CW-1:0]         w_col_eff;
  logic [CW-1:0]         w_col_next;
  logic                  w_wrap;
  logic                  w_fire;

  logic [DATA_WIDTH-1:0] r_lb1 [LINE_WIDTH];
  logic [DATA_WIDTH-1:0] r_lb2 [LINE_WIDTH];
  logic [DATA_WIDTH-1:0] w_lb1_rd;
  logic [DATA_WIDTH-1:0] w_lb2_rd;

  logic [DATA_WIDTH-1:0] r_win [3][3];
  logic                  r_win_valid;

  // A pixel carrying sof is handled as row 0, col 0 regardless of history.
  always_comb begin
    w_col_eff   = sof ? '0 : r_col;
    w_state_eff = sof ? S_ROW0 : r_state;
    w_wrap      = (w_col_eff == COL_LAST);
    w_fire      = din_valid && (w_state_eff == S_RUN) && (w_col_eff >= COL_TWO);
  end

  // Old line-buffer contents are read combinationally so the write below
  // (same address, same edge) cannot disturb the value used this cycle.
  assign w_lb1_rd = r_lb1[w_col_eff];
  assign w_lb2_rd = r_lb2[w_col_eff];

  // Next column and row-fill state; both hold on idle cycles.
  always_comb begin
    w_col_next   = r_col;
    w_state_next = r_state;
    if (din_valid) begin
      w_col_next   = w_wrap ? '0 : w_col_eff + 1'b1;
      w_state_next = w_state_eff;
      if (w_wrap) begin
        case (w_state_eff)
          S_ROW0:  w_state_next = S_ROW1;
          S_ROW1:  w_state_next = S_RUN;
          default: w_state_next = S_RUN;
        endcase
      end
    end
  end

  // Column counter and FSM state register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_col   <= '0;
      r_state <= S_ROW0;
    end else begin
      r_col   <= w_col_next;
      r_state <= w_state_next;
    end
  end

  // Line buffers cascade: LB1 takes the new pixel, LB2 takes LB1's old value.
  // Contents are never reset; the FSM keeps stale data from being flagged.
  always_ff @(posedge clk) begin
    if (din_valid) begin
      r_lb1[w_col_eff] <= din_data;
      r_lb2[w_col_eff] <= w_lb1_rd;
    end
  end

  // Window shifts left and loads a new right-hand column on each pixel.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= '0;
        end
      end
      r_win_valid <= 1'b0;
    end else begin
      r_win_valid <= w_fire;
      if (din_valid) begin
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
        end
        r_win[0][2] <= w_lb2_rd;
        r_win[1][2] <= w_lb1_rd;
        r_win[2][2] <= din_data;
      end
    end
  end

  assign win00     = r_win[0][0];
  assign win01     = r_win[0][1];
  assign win02     = r_win[0][2];
  assign win10     = r_win[1][0];
  assign win11     = r_win[1][1];
  assign win12     = r_win[1][2];
  assign win20     = r_win[2][0];
  assign win21     = r_win[2][1];
  assign win22     = r_win[2][2];
  assign win_valid = r_win_valid;

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3
// Directed and randomized stimulus for window_gen_3x3 with LINE_WIDTH=4.
// The reference model stores the frame as a 2-D image indexed by (row, col)
// and cuts the expected 3x3 neighbourhood straight out of it.
module tb_window_gen_3x3;

  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          arstn;
  logic          sof;
  logic [DW-1:0] din_data;
  logic          din_valid;
  logic [DW-1:0] win00, win01, win02, win10, win11, win12, win20, win21, win22;
  logic          win_valid;

  window_gen_3x3 #(.DATA_WIDTH(DW), .LINE_WIDTH(LW)) dut (
    .clk       (clk),
    .arstn     (arstn),
    .sof       (sof),
    .din_data  (din_data),
    .din_valid (din_valid),
    .win00     (win00),
    .win01     (win01),
    .win02     (win02),
    .win10     (win10),
    .win11     (win11),
    .win12     (win12),
    .win20     (win20),
    .win21     (win21),
    .win22     (win22),
    .win_valid (win_valid)
  );

  always #5 clk = ~clk;

  wire [71:0] obs_win = {win00, win01, win02, win10, win11, win12, win20, win21, win22};

  int          n_checks = 0;
  int          n_fail   = 0;

  // reference model state
  int          m_row;
  int          m_col;
  bit          m_first;
  logic [7:0]  img [8][LW];
  bit          known;
  logic [71:0] exp_win;
  int          n_exp_win;
  logic [71:0] obs_q [$];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] q_at(input int idx);
    if (idx < obs_q.size()) return obs_q[idx];
    return 'x;
  endfunction

  // One clock: drive at the falling edge, check 1 ns after the rising edge.
  task automatic step(input bit v, input bit s, input logic [7:0] d);
    bit          ev;
    logic [71:0] ew;
    @(negedge clk);
    din_valid = v;
    sof       = s;
    din_data  = d;
    @(posedge clk);
    #1;
    if (win_valid === 1'b1) obs_q.push_back(obs_win);
    if (v) begin
      if (s || m_first) begin
        m_row   = 0;
        m_col   = 0;
        m_first = 0;
      end
      img[m_row % 8][m_col] = d;
      ev = (m_row >= 2) && (m_col >= 2);
      ew = '0;
      if (ev) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            ew = {ew[63:0], img[(m_row - 2 + i) % 8][m_col - 2 + j]};
        n_exp_win++;
      end
      $display("px r=%0d c=%0d d=%02h sof=%0b win_valid=%0b win=%018h", m_row, m_col, d, s, win_valid, obs_win);
      check("valid", {71'b0, win_valid}, {71'b0, ev});
      if (ev) check("window", obs_win, ew);
      known   = ev;
      exp_win = ew;
      m_col++;
      if (m_col == LW) begin
        m_col = 0;
        m_row++;
      end
    end else begin
      check("idle_valid", {71'b0, win_valid}, 72'd0);
      if (known) check("idle_hold", obs_win, exp_win);
    end
  endtask

  task automatic model_reset();
    m_first = 1;
    m_row   = 0;
    m_col   = 0;
    known   = 1;
    exp_win = '0;
  endtask

  task automatic send_frame(input int rows, input bit with_sof, input bit gapped);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < LW; c++) begin
        step(1'b1, with_sof && (r == 0) && (c == 0), 8'(r * 16 + c));
        if (gapped) step(1'b0, 1'b0, 8'($urandom));
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arstn     = 1'b0;
    sof       = 1'b0;
    din_valid = 1'b0;
    din_data  = '0;
    model_reset();
    #20;
    check("reset_valid", {71'b0, win_valid}, 72'd0);
    check("reset_win", obs_win, 72'd0);
    @(negedge clk);
    arstn = 1'b1;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 8'($urandom));

    // ordered fill
    obs_q.delete();
    send_frame(4, 1'b1, 1'b0);
    check("fill_count", 72'(obs_q.size()), 72'd4);
    check("fill_first", q_at(0), 72'h000102_101112_202122);
    check("fill_last", q_at(3), 72'h111213_212223_313233);

    // gapped input
    obs_q.delete();
    send_frame(4, 1'b1, 1'b1);
    check("gap_count", 72'(obs_q.size()), 72'd4);
    check("gap_first", q_at(0), 72'h000102_101112_202122);
    check("gap_last", q_at(3), 72'h111213_212223_313233);

    // mid-frame sof on pixel 0x31
    obs_q.delete();
    send_frame(3, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h30);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < LW; c++)
        step(1'b1, (r == 0) && (c == 0), (r == 0 && c == 0) ? 8'h31 : 8'(8'h80 + r * 16 + c));
    check("sof_count", 72'(obs_q.size()), 72'd4);
    check("sof_first_new", q_at(2), 72'h318182_909192_a0a1a2);

    // mid-stream reset during pixel 0x23
    obs_q.delete();
    send_frame(2, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h20);
    step(1'b1, 1'b0, 8'h21);
    step(1'b1, 1'b0, 8'h22);
    check("pre_rst_valid", {71'b0, win_valid}, 72'd1);
    @(negedge clk);
    din_valid = 1'b1;
    din_data  = 8'h23;
    #2 arstn = 1'b0;
    #1;
    check("async_rst_valid", {71'b0, win_valid}, 72'd0);
    check("async_rst_win", obs_win, 72'd0);
    @(posedge clk);
    #2 din_valid = 1'b0;
    @(posedge clk);
    #3 arstn = 1'b1;
    model_reset();
    obs_q.delete();
    send_frame(4, 1'b0, 1'b0);
    check("rst_count", 72'(obs_q.size()), 72'd4);
    check("rst_first", q_at(0), 72'h000102_101112_202122);
    check("rst_last", q_at(3), 72'h111213_212223_313233);

    // random 3-line bursts with random gaps; sof on idle cycles is ignored
    obs_q.delete();
    n_exp_win = 0;
    for (int b = 0; b < 64; b++)
      for (int p = 0; p < 3 * LW; p++) begin
        while ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom), 8'($urandom));
        step(1'b1, p == 0, 8'($urandom));
      end
    check("rand_model_count", 72'(n_exp_win), 72'(64 * (3 - 2) * (LW - 2)));
    check("rand_obs_count", 72'(obs_q.size()), 72'(64 * (3 - 2) * (LW - 2)));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3×3 neighbourhood generator feeding the order-statistics sorters (median, min, max). It accepts a raster-order pixel stream, buffers the two previous lines in on-chip line buffers, and presents a full 3×3 window plus a one-bit valid strobe. Its outputs map one-to-one onto the sorter's `din00..din22` / `din_valid` inputs.

## Interface
- `DATA_WIDTH`, 8, pixel width in bits.
- `LINE_WIDTH`, 640, pixels per line; legal range ≥ 3.
- `clk`  in  1  single clock; all logic is rising-edge.
- `arstn`  in  1  reset, asynchronous, active-low.
- `sof`  in  1  start of frame; sampled only when `din_valid`=1, and marks that pixel as row 0, col 0.
- `din_data`  in  DATA_WIDTH  input pixel.
- `din_valid`  in  1  pixel qualifier; every cycle with `din_valid`=1 accepts one pixel. There is no backpressure.
- `win00..win02`  out  DATA_WIDTH each  window top row (row r-2), left to right (cols c-2..c).
- `win10..win12`  out  DATA_WIDTH each  middle row (r-1).
- `win20..win22`  out  DATA_WIDTH each  bottom row (r, current line).
- `win_valid`  out  1  window complete and inside the image.

## Operation
- **Counters.**
  - `col` is $clog2(LINE_WIDTH) bits. It increments on each accepted pixel and wraps from LINE_WIDTH-1 to 0.
  - A row-fill FSM advances whenever `col` wraps. States: S_ROW0 → S_ROW1 → S_RUN. S_RUN is terminal until the next `sof` or reset.
- **`sof` handling.** An accepted pixel with `sof`=1 is processed as col 0 in S_ROW0, whatever the prior state. Afterwards `col` is 1 and the FSM stays in S_ROW0.
- **Line buffers.** Two memories, LB1 and LB2, each LINE_WIDTH × DATA_WIDTH, addressed by `col`. For each accepted pixel:
  - `lb1_rd` = LB1[col] and `lb2_rd` = LB2[col] (old contents).
  - Write LB1[col] ← `din_data` and LB2[col] ← `lb1_rd`.
  - The read and write happen in the same cycle. The old value must be returned, so use read-before-write or an equivalent bypass.
- **Window shift.** On each accepted pixel:
  - Every row shifts left: x0 ← x1 and x1 ← x2.
  - New right column: `win02` ← `lb2_rd`, `win12` ← `lb1_rd`, `win22` ← `din_data`.
- **Valid.** `win_valid` is registered. It is set to 1 on a cycle accepting a pixel with FSM = S_RUN and `col` ≥ 2 (pre-increment values). It is 0 on every other cycle.
- **Window centre.** `win11` is the pixel at (r-1, c-1).
- **Windows per frame.** A frame of H lines produces (H-2)×(LINE_WIDTH-2) windows. No border padding: edge pixels have no window.
- **Line buffer reset.** Line buffer contents are not reset. Stale data is never flagged valid, because of the FSM gating.
- **Idle cycles.** When `din_valid`=0, all state and window outputs hold and `win_valid`=0.
- **Reset values.** While `arstn`=0: `col`=0, FSM=S_ROW0, all `winXY`=0, `win_valid`=0.
  - Reset mid-frame discards the frame.
  - The first pixel after reset is treated as row 0, col 0 whether or not `sof` is set.

## Timing
- Latency is 1 clock. `win_valid` and the window appear on the rising edge after the edge that accepts pixel (r, c), and `win22` equals that pixel.
- Throughput is one window per accepted pixel in S_RUN, sustaining back-to-back `din_valid`.
- Line wrap:
  - Pixels at col 0 and col 1 of each line produce `win_valid`=0, even in S_RUN.
  - The window registers still shift on these pixels, so columns from the previous line are flushed out.
- Simultaneous events:
  - `sof`=1 on a pixel that is also col LINE_WIDTH-1: `sof` wins and `col` becomes 1.
  - `sof`=1 while S_RUN and `col` ≥ 2: that pixel does not raise `win_valid`.
- Asynchronous assert of `arstn` clears `win_valid` immediately, with no wait for a clock edge. Deassertion is synchronous to the testbench's stimulus (driven at least 2 ns after a `clk` rising edge).

## Test plan
- **Reset.** Drive `arstn`=0 for 20 ns, then `din_valid`=0 for 10 cycles → all `winXY`=0 and `win_valid`=0 throughout.
- **Ordered fill.** LINE_WIDTH=4, DATA_WIDTH=8, continuous 4×4 frame with pixel = {row,col} nibbles, `sof` on the first pixel.
  - Exactly 4 `win_valid` pulses, one cycle after pixels 0x22, 0x23, 0x32, 0x33.
  - First window: win00..22 = 00, 01, 02, 10, 11, 12, 20, 21, 22.
  - Last window: 11, 12, 13, 21, 22, 23, 31, 32, 33.
- **Gapped input.** Same frame with `din_valid` toggling 1/0 → identical 4 windows in the same order. Each `win_valid` is high exactly 1 cycle after an accepted pixel, and window outputs hold across gaps.
- **Mid-frame `sof`.** In the ordered frame, assert `sof` with pixel 0x31 → no `win_valid` from that pixel onward until the pixel at new row 2, col 2. The next window contains only new-frame data.
- **Mid-stream reset.** Pulse `arstn` low during pixel 0x23 → `win_valid` drops asynchronously. A following full 4×4 frame without `sof` yields exactly the 4 windows of the ordered-fill test.
- **Sorter connection.** 64 random 3-line bursts into window_gen_3x3 driving the median sorter → each sorter output equals the software median of the corresponding window, and the output count is (H-2)×(LINE_WIDTH-2).
